// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one synchronous FIFO write port among NUM_REQ producers.
// Define FIFO_ARB_BURST_EN to compile in burst locking (LOCK state, owner, beat_cnt).
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_cs,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy
);

  localparam int unsigned PW = $clog2(NUM_REQ);

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] idx;
  logic          found;
  logic          xfer;

  // First valid producer at or after ptr, wrapping; falls back to ptr when none is valid.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PW'((32'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign ptr_next = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);

  assign xfer       = !rst && !fifo_full && req_valid[grant_id];
  assign fifo_wr_en = xfer;
  assign fifo_cs    = xfer;

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready = NUM_REQ'(1) << grant_id;
  end

  always_comb begin
    fifo_data_in = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == grant_id) fifo_data_in = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        state;
  logic [PW-1:0] owner;
  logic [CW-1:0] beat_cnt;
  logic          locked;

  // Reset overrides LOCK combinationally so busy and grant_id follow IDLE while rst is high.
  assign locked   = (state == LOCK) && !rst;
  assign grant_id = locked ? owner : win;
  assign busy     = locked;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else if (xfer) begin
      if (state == IDLE) begin
        ptr <= ptr_next;
        if (!req_last[win] && MAX_BURST > 1) begin
          state    <= LOCK;
          owner    <= win;
          beat_cnt <= CW'(1);
        end
      end else begin
        beat_cnt <= beat_cnt + CW'(1);
        if (req_last[owner] || (beat_cnt + CW'(1)) == CW'(MAX_BURST)) state <= IDLE;
      end
    end
  end
`else
  logic unused_cfg;

  assign grant_id   = win;
  assign busy       = 1'b0;
  assign unused_cfg = (^req_last) ^ (MAX_BURST == 0);

  always_ff @(posedge clk) begin
    if (rst)       ptr <= '0;
    else if (xfer) ptr <= ptr_next;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed-vector bench for fifo_wr_arbiter; burst-lock vectors build only with FIFO_ARB_BURST_EN.
module tb_fifo_wr_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 4;
  localparam int unsigned GW = $clog2(NR);

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              fifo_full;
  logic              fifo_cs;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_data_in;
  logic [GW-1:0]     grant_id;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;
  int n_wr  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (fifo_wr_en) n_wr <= n_wr + 1;

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_WIDTH(DW),
    .MAX_BURST (MB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_cs     (fifo_cs),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_data_in(fifo_data_in),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic setd(input int unsigned i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are already set; check combinational outputs, then advance one clock.
  task automatic cyc(input string tag, input logic wr, input int unsigned gid,
                     input logic [DW-1:0] data, input logic bsy);
    logic [NR-1:0] rdy;
    #1;
    rdy = wr ? (NR'(1) << gid) : '0;
    check({tag, ".wr_en"}, 64'(fifo_wr_en), 64'(wr));
    check({tag, ".cs"},    64'(fifo_cs),    64'(wr));
    check({tag, ".grant"}, 64'(grant_id),   64'(gid));
    check({tag, ".ready"}, 64'(req_ready),  64'(rdy));
    check({tag, ".data"},  64'(fifo_data_in), 64'(data));
    check({tag, ".busy"},  64'(busy),       64'(bsy));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    rst       = 1'b1;
    fifo_full = 1'b0;
    req_valid = '1;
    req_last  = '1;
    req_data  = '0;
    for (int unsigned i = 0; i < NR; i++) setd(i, 32'hD0D0_0000 + i);
    tick();

    // Reset held with every producer valid: nothing accepted, selection from ptr 0.
    cyc("rst0", 1'b0, 0, 32'hD0D0_0000, 1'b0);
    cyc("rst1", 1'b0, 0, 32'hD0D0_0000, 1'b0);
    rst = 1'b0;
    cyc("rel", 1'b1, 0, 32'hD0D0_0000, 1'b0);
    req_valid = '0;
    cyc("ptr1", 1'b0, 1, 32'hD0D0_0001, 1'b0);

    // Fairness: all valid for 8 cycles from ptr 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef FIFO_ARB_BURST_EN
    req_last = '1;
`else
    req_last = '0;
`endif
    req_valid = '1;
    w0 = n_wr;
    for (int unsigned k = 0; k < 8; k++) cyc("fair", 1'b1, k % NR, 32'hD0D0_0000 + (k % NR), 1'b0);
    check("fair.writes", 64'(n_wr - w0), 64'd8);

    // Full stall: producer 1 waits three cycles, then writes on the first non-full cycle.
    req_last  = '1;
    req_valid = 4'b0010;
    setd(1, 32'hA5A5_0001);
    fifo_full = 1'b1;
    for (int unsigned k = 0; k < 3; k++) cyc("full", 1'b0, 1, 32'hA5A5_0001, 1'b0);
    fifo_full = 1'b0;
    cyc("unfull", 1'b1, 1, 32'hA5A5_0001, 1'b0);
    req_valid = '0;
    cyc("ptr2", 1'b0, 2, 32'hD0D0_0002, 1'b0);

`ifdef FIFO_ARB_BURST_EN
    // Burst cap: producer 2 streams with no last, producer 0 waiting -> 2,2,2,2,0,2,2.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b0010;
    cyc("bc.pre", 1'b1, 1, 32'hA5A5_0001, 1'b0);
    req_last  = 4'b1011;
    req_valid = 4'b0101;
    for (int unsigned b = 1; b <= 4; b++) begin
      setd(2, 32'h2000_0000 + b);
      cyc("bc.lock", 1'b1, 2, 32'h2000_0000 + b, b != 1);
    end
    setd(2, 32'h2000_0005);
    cyc("bc.p0", 1'b1, 0, 32'hD0D0_0000, 1'b0);
    cyc("bc.b5", 1'b1, 2, 32'h2000_0005, 1'b0);
    setd(2, 32'h2000_0006);
    cyc("bc.b6", 1'b1, 2, 32'h2000_0006, 1'b1);
    req_valid = 4'b0001;
    cyc("bc.stall", 1'b0, 2, 32'h2000_0006, 1'b1);

    // Early last: producer 3 ends its burst on beat 2, then producer 1 is served.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_last  = '1;
    req_valid = 4'b0100;
    setd(2, 32'hD0D0_0002);
    cyc("el.pre", 1'b1, 2, 32'hD0D0_0002, 1'b0);
    req_valid = 4'b1010;
    req_last  = 4'b0111;
    setd(3, 32'h3000_0001);
    cyc("el.b1", 1'b1, 3, 32'h3000_0001, 1'b0);
    req_last  = '1;
    setd(3, 32'h3000_0002);
    cyc("el.b2", 1'b1, 3, 32'h3000_0002, 1'b1);
    req_valid = 4'b0010;
    cyc("el.p1", 1'b1, 1, 32'hA5A5_0001, 1'b0);

    // Reset mid-LOCK: partial burst abandoned, arbitration restarts from index 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b0100;
    req_last  = 4'b1011;
    setd(2, 32'h4000_0001);
    cyc("ml.b1", 1'b1, 2, 32'h4000_0001, 1'b0);
    setd(2, 32'h4000_0002);
    cyc("ml.b2", 1'b1, 2, 32'h4000_0002, 1'b1);
    rst = 1'b1;
    cyc("ml.rst", 1'b0, 2, 32'h4000_0002, 1'b0);
    rst = 1'b0;
    req_last  = '1;
    req_valid = 4'b1110;
    cyc("ml.after", 1'b1, 1, 32'hA5A5_0001, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
